// File: rtl/lut_arbiter.sv
// Lookup-table controller: loads default contents after reset, then shares one
// read port between two round-robin requesters, with configuration writes taking priority.
module lut_arbiter #(
  parameter int LOG2_WIDTH = 3,
  parameter int WIDTH      = 2**LOG2_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req0_valid,
  input  logic [LOG2_WIDTH-1:0] req0_addr,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [LOG2_WIDTH-1:0] req1_addr,
  output logic                  req1_ready,
  input  logic                  cfg_we,
  input  logic [LOG2_WIDTH-1:0] cfg_addr,
  input  logic [WIDTH-1:0]      cfg_data,
  output logic                  cfg_ready,
  output logic                  init_done,
  output logic [WIDTH-1:0]      out,
  output logic                  out_id,
  output logic                  strobe
);

  typedef enum logic {INIT, RUN} state_t;

  state_t                state;
  state_t                state_next;
  logic [LOG2_WIDTH-1:0] idx;
  logic                  last_grant;
  logic                  grant0;
  logic                  grant1;
  logic                  wr_en;
  logic [LOG2_WIDTH-1:0] wr_addr;
  logic [WIDTH-1:0]      wr_data;
  logic [LOG2_WIDTH-1:0] rd_addr;
  logic [WIDTH-1:0]      lut [WIDTH];

  // The default load and cfg writes share one write port; they never overlap
  // because cfg writes are only accepted in RUN.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    state_next = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    cfg_ready  = 1'b0;
    wr_en      = 1'b0;
    wr_addr    = idx;
    wr_data    = WIDTH'(idx) + WIDTH'(1);
    unique case (state)
      INIT: begin
        wr_en = 1'b1;
        if (idx == LOG2_WIDTH'(WIDTH-1)) state_next = RUN;
      end
      RUN: begin
        if (cfg_we) begin
          cfg_ready = 1'b1;
          wr_en     = 1'b1;
          wr_addr   = cfg_addr;
          wr_data   = cfg_data;
        end else begin
          // last_grant==1 means requester 1 won most recently, so 0 wins a tie.
          grant0 = req0_valid && (!req1_valid || last_grant);
          grant1 = req1_valid && (!req0_valid || !last_grant);
        end
      end
    endcase
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rd_addr    = grant1 ? req1_addr : req0_addr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= INIT;
      idx        <= '0;
      last_grant <= 1'b1;
      init_done  <= 1'b0;
      out        <= '0;
      out_id     <= 1'b0;
      strobe     <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state  <= state_next;
      strobe <= grant0 | grant1;
      if (state == INIT) idx <= idx + LOG2_WIDTH'(1);
      if (state == INIT && state_next == RUN) init_done <= 1'b1;
      if (grant0 | grant1) begin
        out        <= lut[rd_addr];
        out_id     <= grant1;
        last_grant <= grant1;
      end
    end
  end

  // NOTE: the table has no reset; INIT rewrites every entry before any read
  // can be granted, so a reset network on the array would buy nothing.
  always_ff @(posedge clock) begin
    if (wr_en) lut[wr_addr] <= wr_data;
  end

endmodule

// File: doc/lut_arbiter.md
# lut_arbiter

Controller for the WIDTH-entry lookup table used by the lookup datapath. After reset it loads the table with its default contents (entry j = j+1). It then shares the single read port between two requesters with a round-robin arbiter, and accepts configuration writes at higher priority. Each granted lookup returns one registered result with a one-cycle strobe.

## Interface
- WIDTH, default 2**LOG2_WIDTH: data width and table depth.
- LOG2_WIDTH, default 3: address width.
- clock  input  1  sole clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req0_valid / req1_valid  input  1  lookup request from requester 0 / 1.
- req0_addr / req1_addr  input  LOG2_WIDTH  table index for requester 0 / 1.
- req0_ready / req1_ready  output  1  grant; transfer when valid && ready.
- cfg_we  input  1  configuration write request.
- cfg_addr  input  LOG2_WIDTH  write index.
- cfg_data  input  WIDTH  write data.
- cfg_ready  output  1  high when a cfg write is accepted this cycle.
- init_done  output  1  high once the default load is complete.
- out  output  WIDTH  lookup result, registered.
- out_id  output  1  requester that owns the current result.
- strobe  output  1  one-cycle pulse, high when out/out_id are new.

## Operation
- Storage: WIDTH x WIDTH register array, owned exclusively by this block.
- FSM states: INIT, RUN.
- INIT is entered on reset assertion:
  - Index counter idx starts at 0.
  - Each cycle, lut[idx] <= idx+1, truncated to WIDTH bits, then idx increments.
  - After the write of entry WIDTH-1, the FSM moves to RUN and sets init_done.
  - In INIT, all ready outputs are 0 and requests are ignored.
- RUN, configuration path:
  - cfg_ready = cfg_we.
  - Accepted write: lut[cfg_addr] <= cfg_data.
  - A cycle with cfg_we high grants no read (both req*_ready = 0).
- RUN, read arbitration (cfg_we low):
  - One valid requester: that requester is granted.
  - Both valid: grant the requester that was NOT granted most recently.
  - Pointer last_grant resets to 1, so req0 wins the first contention.
  - last_grant updates only on an actual transfer.
- Ready depends combinationally on valid, state, cfg_we and last_grant. Requesters hold valid and addr stable until their ready is seen high.
- On a read transfer, at the next edge:
  - out <= lut[addr].
  - out_id <= granted index.
  - strobe <= 1.
- Otherwise strobe <= 0, and out and out_id hold their values.
- Read-during-write: reads and writes are never granted in the same cycle. A read granted in the cycle after a cfg write returns the new data.
- Addresses span the full range 0..WIDTH-1; no out-of-range case exists.

## Timing
- Reset values (async): state=INIT, idx=0, last_grant=1, out=0, out_id=0, strobe=0, init_done=0. req*_ready=0 and cfg_ready=0 combinationally. Table contents are undefined until rewritten by INIT.
- INIT length: the first rising edge after reset_n deasserts is edge 1; edge k writes entry k-1.
- init_done is registered high by edge WIDTH, so RUN begins in the cycle after edge WIDTH.
- Read latency: 1 cycle. Transfer at edge n gives strobe high for the cycle after edge n, with valid out.
- Throughput: one read per cycle, sustainable back-to-back. With both requesters continuously valid, grants alternate every cycle.
- cfg writes: zero-latency accept, effective at the same edge.
- Reset mid-operation:
  - Outputs clear immediately on reset assertion.
  - Any in-flight result is dropped, with no strobe.
  - The full INIT sequence reruns, and any cfg-written contents are overwritten.

## Test plan
- Reset release, WIDTH=8: init_done rises after edge 8. No ready during INIT even with both valids high. Reads of addr 0..7 return 1..8.
- Single request, req0 addr=5 in RUN: req0_ready high the same cycle. Next cycle strobe=1, out=6, out_id=0. The cycle after, strobe=0 and out holds 6.
- Both requesters continuously valid, addr0=2, addr1=7: grants go req0, req1, req0, … out alternates 3, 8, 3 with out_id 0, 1, 0.
- cfg_we with addr=3, data=0xA5 while both requests are valid: cfg_ready=1 and both ready=0 that cycle. A read of addr 3 granted the next cycle returns 0xA5.
- Assert reset_n low during a granted read and after a cfg write to addr 3: strobe and out clear immediately. The transaction is lost, INIT reruns, and a subsequent read of addr 3 returns 4.
- Single requester valid for 10 consecutive cycles with incrementing addr: 10 consecutive strobes with one-cycle latency, no bubbles.
